scram_lanes: RTL and testbench

Parametrised multi-lane self-synchronising scrambler/descrambler for the 64b/66b PCS, polynomial G(x) = 1 + x^39 + x^58 (IEEE 802.3 cl. 49).
- One instance serves LANE_N independent lanes of LEN bits per cycle.
- Compile-time mode selects TX scramble or RX descramble.
- Registered outputs.
- Sits between the 64b/66b encoder and the gearbox on TX, and between block alignment and the decoder on RX.

---
 rtl/scram_lanes.sv | 121 ++++++++++++
 tb/tb_scram_lanes.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/scram_lanes.sv
// -----------------------------------------------------------------------------
// scram_lanes
//   Multi-lane self-synchronising scrambler / descrambler for the 64b/66b PCS,
//   polynomial G(x) = 1 + x^39 + x^58. Each lane keeps its own 58-bit history
//   of the scrambled stream and processes LEN bits per cycle, LSB first, fully
//   unrolled. Outputs are registered (1-cycle latency).
//
// Parameters
//   LANE_N : number of independent lanes (>= 1)
//   LEN    : data bits per lane per cycle (1..64)
//   MODE   : 0 = scramble (TX), 1 = descramble (RX)
//   SEED   : per-lane state value loaded at reset
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-high reset
//   valid_i      in   [LANE_N]       per-lane word valid
//   data_i       in   [LANE_N*LEN]   lane l at [l*LEN +: LEN], bit 0 first on wire
//   valid_o      out  [LANE_N]       registered copy of valid_i
//   data_o       out  [LANE_N*LEN]   scrambled / descrambled words, same packing
//   seed_load_i  in   1              (SCRAM_SEED_LOAD_EN only) load seed_i into all lanes
//   seed_i       in   [58]           (SCRAM_SEED_LOAD_EN only) seed value
//
// Optional feature macro: SCRAM_SEED_LOAD_EN (adds the run-time seed load).
// -----------------------------------------------------------------------------
module scram_lanes #(
    parameter int unsigned LANE_N = 4,
    parameter int unsigned LEN    = 32,
    parameter int unsigned MODE   = 0,
    parameter logic [57:0] SEED   = 58'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANE_N-1:0]       valid_i,
    input  logic [LANE_N*LEN-1:0]   data_i,
    output logic [LANE_N-1:0]       valid_o,
    output logic [LANE_N*LEN-1:0]   data_o
`ifdef SCRAM_SEED_LOAD_EN
    ,
    input  logic                    seed_load_i,
    input  logic [57:0]             seed_i
`endif
);

    localparam int unsigned SW    = 58;   // state width
    localparam int unsigned TAP_A = 39;   // x^39 tap distance
    localparam int unsigned TAP_B = 58;   // x^58 tap distance
    localparam logic        DESCRAMBLE = (MODE != 0);

    for (genvar l = 0; l < LANE_N; l++) begin : g_lane
        logic [SW-1:0]  state_q;
        logic [SW-1:0]  state_d;
        logic [SW-1:0]  start_c;
        logic [SW-1:0]  run_c;
        logic [SW-1:0]  end_c;
        logic [LEN-1:0] word_in_c;
        logic [LEN-1:0] word_out_c;
        logic [LEN-1:0] data_q;
        logic [LEN-1:0] data_d;
        logic           valid_q;
        logic           valid_d;
        logic           fb_c;
        logic           sbit_c;

        assign word_in_c = data_i[l*LEN +: LEN];

        // Starting state for this cycle's word: a seed load overrides history.
`ifdef SCRAM_SEED_LOAD_EN
        assign start_c = seed_load_i ? seed_i : state_q;
`else
        assign start_c = state_q;
`endif

        // Bit-serial recurrence unrolled across the word. run_c[k] is the
        // scrambled bit k+1 positions back, so taps reaching into the current
        // word automatically see the bits computed earlier in this loop.
        always_comb begin
            run_c      = start_c;
            word_out_c = '0;
            fb_c       = 1'b0;
            sbit_c     = 1'b0;
            for (int j = 0; j < int'(LEN); j++) begin
                fb_c          = run_c[TAP_A-1] ^ run_c[TAP_B-1];
                word_out_c[j] = word_in_c[j] ^ fb_c;
                // History always tracks the scrambled stream: the output when
                // scrambling, the received input when descrambling.
                sbit_c        = DESCRAMBLE ? word_in_c[j] : word_out_c[j];
                run_c         = {run_c[SW-2:0], sbit_c};
            end
            end_c = run_c;
        end

        // Next-state: valid words advance the lane, idle cycles hold
        // (or pick up a freshly loaded seed).
        always_comb begin
            state_d = start_c;
            data_d  = data_q;
            valid_d = valid_i[l];
            if (valid_i[l]) begin
                state_d = end_c;
                data_d  = word_out_c;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= SEED;
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign data_o[l*LEN +: LEN] = data_q;
        assign valid_o[l]           = valid_q;
    end

endmodule

// File: tb/tb_scram_lanes.sv
// -----------------------------------------------------------------------------
// tb_scram_lanes
//   Directed table of known scrambler vectors on a 2-lane, 32-bit TX instance,
//   hand sequences for asynchronous reset and seed load, and TX->RX round trips
//   (LEN 32, LEN 64, and an RX with a mismatched seed).
// -----------------------------------------------------------------------------
module tb_scram_lanes;

    logic         clk;
    logic         reset;
    logic [1:0]   valid;
    logic [63:0]  data;
    logic [1:0]   vo;
    logic [63:0]  dout;
    logic         seed_load;
    logic [57:0]  seed;

    logic [1:0]   rt_v;
    logic [63:0]  rt_d32;
    logic [127:0] rt_d64;
    logic [1:0]   t32_v, r32_v, rb_v, t64_v, r64_v;
    logic [63:0]  t32_d, r32_d, rb_d;
    logic [127:0] t64_d, r64_d;

    int checks = 0;
    int errors = 0;

    scram_lanes #(.LANE_N(2), .LEN(32), .MODE(0), .SEED(58'h0)) dut (
        .clk(clk), .reset(reset), .valid_i(valid), .data_i(data),
        .valid_o(vo), .data_o(dout)
`ifdef SCRAM_SEED_LOAD_EN
        , .seed_load_i(seed_load), .seed_i(seed)
`endif
    );

    scram_lanes #(.LANE_N(2), .LEN(32), .MODE(0), .SEED(58'h0)) tx32 (
        .clk(clk), .reset(reset), .valid_i(rt_v), .data_i(rt_d32),
        .valid_o(t32_v), .data_o(t32_d)
`ifdef SCRAM_SEED_LOAD_EN
        , .seed_load_i(1'b0), .seed_i(58'h0)
`endif
    );

    scram_lanes #(.LANE_N(2), .LEN(32), .MODE(1), .SEED(58'h0)) rx32 (
        .clk(clk), .reset(reset), .valid_i(t32_v), .data_i(t32_d),
        .valid_o(r32_v), .data_o(r32_d)
`ifdef SCRAM_SEED_LOAD_EN
        , .seed_load_i(1'b0), .seed_i(58'h0)
`endif
    );

    scram_lanes #(.LANE_N(2), .LEN(32), .MODE(1), .SEED(58'h155)) rxbad (
        .clk(clk), .reset(reset), .valid_i(t32_v), .data_i(t32_d),
        .valid_o(rb_v), .data_o(rb_d)
`ifdef SCRAM_SEED_LOAD_EN
        , .seed_load_i(1'b0), .seed_i(58'h0)
`endif
    );

    scram_lanes #(.LANE_N(2), .LEN(64), .MODE(0), .SEED(58'h0)) tx64 (
        .clk(clk), .reset(reset), .valid_i(rt_v), .data_i(rt_d64),
        .valid_o(t64_v), .data_o(t64_d)
`ifdef SCRAM_SEED_LOAD_EN
        , .seed_load_i(1'b0), .seed_i(58'h0)
`endif
    );

    scram_lanes #(.LANE_N(2), .LEN(64), .MODE(1), .SEED(58'h0)) rx64 (
        .clk(clk), .reset(reset), .valid_i(t64_v), .data_i(t64_d),
        .valid_o(r64_v), .data_o(r64_d)
`ifdef SCRAM_SEED_LOAD_EN
        , .seed_load_i(1'b0), .seed_i(58'h0)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  ev;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_row(input int i, input logic rst, input logic [1:0] v,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] ev, input logic [31:0] e0, input logic [31:0] e1);
        tbl[i].rst = rst; tbl[i].v  = v;  tbl[i].d0 = d0; tbl[i].d1 = d1;
        tbl[i].ev  = ev;  tbl[i].e0 = e0; tbl[i].e1 = e1;
    endtask

    logic [1:0]   prev_v;
    logic [63:0]  prev_d32;
    logic [127:0] prev_d64;
    int           nbad [2];

    initial begin
        clk = 1'b0; reset = 1'b1; valid = '0; data = '0;
        seed_load = 1'b0; seed = '0;
        rt_v = '0; rt_d32 = '0; rt_d64 = '0;

        //          rst  v      d0            d1            ev     e0            e1
        set_row( 0, 1, 2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0);
        set_row( 1, 0, 2'b01, 32'h00000001, 32'h0,        2'b01, 32'h00000001, 32'h0);
        set_row( 2, 0, 2'b01, 32'h00000000, 32'h0,        2'b01, 32'h04000080, 32'h0);
        set_row( 3, 0, 2'b10, 32'h0,        32'h00000001, 2'b10, 32'h04000080, 32'h00000001);
        set_row( 4, 0, 2'b00, 32'h0,        32'h0,        2'b00, 32'h04000080, 32'h00000001);
        set_row( 5, 0, 2'b10, 32'h0,        32'h00000000, 2'b10, 32'h04000080, 32'h04000080);
        set_row( 6, 1, 2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0);
        set_row( 7, 0, 2'b11, 32'h00000001, 32'h00000001, 2'b11, 32'h00000001, 32'h00000001);
        set_row( 8, 1, 2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0);
        set_row( 9, 0, 2'b01, 32'h00000000, 32'h0,        2'b01, 32'h00000000, 32'h0);
        set_row(10, 0, 2'b01, 32'hFFFFFFFF, 32'h0,        2'b01, 32'hFFFFFFFF, 32'h0);
        set_row(11, 0, 2'b01, 32'h00000000, 32'h0,        2'b01, 32'h03FFFF80, 32'h0);
        set_row(12, 0, 2'b11, 32'h00000000, 32'h80000000, 2'b11, 32'hFC003F80, 32'h80000000);
        set_row(13, 1, 2'b00, 32'h0,        32'h0,        2'b00, 32'h0,        32'h0);
        set_row(14, 0, 2'b01, 32'h00000001, 32'h0,        2'b01, 32'h00000001, 32'h0);
        set_row(15, 0, 2'b00, 32'h0,        32'h0,        2'b00, 32'h00000001, 32'h0);
        set_row(16, 0, 2'b01, 32'h00000000, 32'h0,        2'b01, 32'h04000080, 32'h0);

        repeat (2) @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = tbl[i].rst;
            valid = tbl[i].v;
            data  = {tbl[i].d1, tbl[i].d0};
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid_o", i), 64'(vo), 64'(tbl[i].ev));
            chk($sformatf("row%0d lane0", i), 64'(dout[31:0]), 64'(tbl[i].e0));
            chk($sformatf("row%0d lane1", i), 64'(dout[63:32]), 64'(tbl[i].e1));
        end

        // Asynchronous reset between edges clears outputs immediately and holds them.
        @(negedge clk);
        valid = 2'b11; data = 64'h00000005_00000003;
        #2 reset = 1'b1;
        #1;
        chk("async rst valid_o", 64'(vo), 64'h0);
        chk("async rst data_o", dout, 64'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst held valid_o", 64'(vo), 64'h0);
            chk("rst held data_o", dout, 64'h0);
        end
        @(negedge clk);
        reset = 1'b0; valid = 2'b00; data = '0;

`ifdef SCRAM_SEED_LOAD_EN
        // Seed load in the same cycle as a lane0 word; lane1 idles and keeps the seed.
        @(negedge clk);
        seed_load = 1'b1; seed = 58'h3FF_FFFF_FFFF_FFFF;
        valid = 2'b01; data = 64'h0;
        @(posedge clk); #1;
        chk("seed lane0 w0", 64'(dout[31:0]), 64'h0);
        @(negedge clk);
        seed_load = 1'b0; seed = '0;
        valid = 2'b11; data = 64'h0;
        @(posedge clk); #1;
        chk("seed lane0 w1", 64'(dout[31:0]), 64'h03FFFF80);
        chk("seed lane1 w0", 64'(dout[63:32]), 64'h0);
        @(negedge clk);
        valid = 2'b10; data = 64'h0;
        @(posedge clk); #1;
        chk("seed lane1 w1", 64'(dout[63:32]), 64'h03FFFF80);
        @(negedge clk);
        valid = 2'b00;
`endif

        // Round trips: RX output after edge k+1 equals TX input sampled at edge k.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        prev_v = '0; prev_d32 = '0; prev_d64 = '0;
        nbad[0] = 0; nbad[1] = 0;
        for (int i = 0; i < 203; i++) begin
            @(negedge clk);
            prev_v   = rt_v;
            prev_d32 = rt_d32;
            prev_d64 = rt_d64;
            if (i < 200) begin
                rt_v   = 2'($urandom_range(0, 3));
                rt_d32 = {$urandom, $urandom};
                rt_d64 = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                rt_v = '0;
            end
            @(posedge clk);
            #1;
            if (i > 0) begin
                chk("rt32 valid", 64'(r32_v), 64'(prev_v));
                chk("rt64 valid", 64'(r64_v), 64'(prev_v));
                for (int l = 0; l < 2; l++) begin
                    if (prev_v[l]) begin
                        chk($sformatf("rt32 lane%0d cyc%0d", l, i),
                            64'(r32_d[l*32 +: 32]), 64'(prev_d32[l*32 +: 32]));
                        chk($sformatf("rt64 lane%0d cyc%0d", l, i),
                            r64_d[l*64 +: 64], prev_d64[l*64 +: 64]);
                    end
                    if (rb_v[l]) begin
                        if (nbad[l] >= 2)
                            chk($sformatf("rtbad lane%0d word%0d", l, nbad[l]),
                                64'(rb_d[l*32 +: 32]), 64'(prev_d32[l*32 +: 32]));
                        nbad[l]++;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
